// File: rtl/rf_multiport.sv
// Multiport register file: NRD registered read ports, one write port, optional
// write-first bypass, hardwired zero entry, reset preset entry and a sequential clear engine.
module rf_multiport #(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 5,
   parameter int                NRD        = 2,
   parameter int                BYPASS     = 1,
   parameter int                ZERO_REG   = 1,
   parameter int                PRESET_IDX = 16,
   parameter logic [DATA_W-1:0] PRESET_VAL = DATA_W'(32'h17)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [NRD-1:0]          rd_en,
   input  logic [NRD*ADDR_W-1:0]   rd_addr,
   output logic [NRD*DATA_W-1:0]   rd_data,
   input  logic                    clr_req,
   output logic                    clr_busy,
   output logic                    clr_done
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0]   rd_addr_k [NRD];
   logic [DATA_W-1:0]   rd_val [NRD];
   logic [DATA_W-1:0]   rd_p0 [NRD];
   logic                wr_ok;

   function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   // Value an entry takes on reset and when scrubbed by the clear engine.
   function automatic logic [DATA_W-1:0] preset_of(input logic [ADDR_W-1:0] idx);
      if (is_zero_addr(idx))
         return '0;
      return (idx == ADDR_W'(PRESET_IDX)) ? PRESET_VAL : '0;
   endfunction

   assign wr_ok    = we && (state == IDLE) && !is_zero_addr(wr_addr);
   assign clr_busy = (state == CLEAR);
   assign clr_done = (state == DONE);

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt   = CLEAR;
               clr_idx_nxt = '0;
            end
         end
         CLEAR: begin
            clr_idx_nxt = clr_idx + ADDR_W'(1);
            if (&clr_idx)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   // The clear engine owns the write path while it runs; user writes only land in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= preset_of(ADDR_W'(i));
      end else if (state == CLEAR) begin
         mem[clr_idx] <= preset_of(clr_idx);
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_port
      assign rd_addr_k[k]                = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_data[k*DATA_W +: DATA_W] = rd_p0[k];
   end

   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         rd_val[k] = mem[rd_addr_k[k]];
         if (is_zero_addr(rd_addr_k[k]))
            rd_val[k] = '0;
         else if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr_k[k]))
            rd_val[k] = wr_data;
      end
   end

   // Read stage boundary: per-port capture register, held while rd_en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NRD; k++)
            rd_p0[k] <= '0;
      end else begin
         for (int k = 0; k < NRD; k++)
            if (rd_en[k])
               rd_p0[k] <= rd_val[k];
      end
   end

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: one BYPASS=1 and one BYPASS=0 instance driven identically.
module tb_rf_multiport;

   localparam int DEPTH = 32;
   localparam int PIDX  = 16;
   localparam logic [31:0] PVAL = 32'h17;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [1:0]  rd_en = '0;
   logic [9:0]  rd_addr = '0;
   logic        clr_req = 1'b0;
   logic [63:0] rd_data_a, rd_data_b;
   logic        busy_a, done_a, busy_b, done_b;

   always #5 clk = ~clk;

   rf_multiport #(.BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a));

   rf_multiport #(.BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b));

   typedef struct {
      int          due;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t  sb[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   string kname [8] = '{"a_rd0", "a_rd1", "b_rd0", "b_rd1", "a_busy", "a_done", "b_busy", "b_done"};

   // Reference model: array contents, per-port held outputs, cycles left in the clear window.
   logic [31:0] m [DEPTH];
   logic [31:0] hold_a [2];
   logic [31:0] hold_b [2];
   int          clr_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int kind);
      case (kind)
         0: return rd_data_a[31:0];
         1: return rd_data_a[63:32];
         2: return rd_data_b[31:0];
         3: return rd_data_b[63:32];
         4: return {31'b0, busy_a};
         5: return {31'b0, done_a};
         6: return {31'b0, busy_b};
         default: return {31'b0, done_b};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.due < cyc)
            check({kname[e.kind], "_late"}, 32'd1, 32'd0);
         else
            check(kname[e.kind], actual(e.kind), e.exp);
      end
   end

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++)
         m[i] = (i == PIDX) ? PVAL : 32'd0;
      for (int k = 0; k < 2; k++) begin
         hold_a[k] = '0;
         hold_b[k] = '0;
      end
      clr_cnt = 0;
   endtask

   task automatic check_reset_outputs();
      for (int k = 0; k < 8; k++)
         check({kname[k], "_rst"}, actual(k), 32'd0);
   endtask

   // One clock of stimulus; the model predicts what the outputs show after the next edge.
   task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                        input logic cr);
      logic        idle, wacc;
      logic [4:0]  ra;
      logic [31:0] old;
      int          pos;
      @(posedge clk);
      #1;
      we = w; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = {a1, a0}; clr_req = cr;
      idle = (clr_cnt == 0);
      wacc = idle && w && (wa != 5'd0);
      for (int k = 0; k < 2; k++) begin
         ra = (k == 0) ? a0 : a1;
         if (re[k]) begin
            old       = (ra == 5'd0) ? 32'd0 : m[ra];
            hold_b[k] = old;
            hold_a[k] = (wacc && wa == ra) ? wd : old;
         end
      end
      if (clr_cnt > 0) begin
         pos = DEPTH + 1 - clr_cnt;
         if (pos < DEPTH)
            m[pos] = (pos == PIDX) ? PVAL : 32'd0;
         clr_cnt--;
      end else if (cr) begin
         clr_cnt = DEPTH + 1;
      end
      if (wacc)
         m[wa] = wd;
      sb.push_back('{cyc + 1, 0, hold_a[0]});
      sb.push_back('{cyc + 1, 1, hold_a[1]});
      sb.push_back('{cyc + 1, 2, hold_b[0]});
      sb.push_back('{cyc + 1, 3, hold_b[1]});
      sb.push_back('{cyc + 1, 4, {31'b0, clr_cnt >= 2}});
      sb.push_back('{cyc + 1, 5, {31'b0, clr_cnt == 1}});
      sb.push_back('{cyc + 1, 6, {31'b0, clr_cnt >= 2}});
      sb.push_back('{cyc + 1, 7, {31'b0, clr_cnt == 1}});
   endtask

   // Lets pending expectations drain, then asserts reset mid-cycle and releases it away from an edge.
   task automatic mid_reset();
      @(posedge clk);
      @(negedge clk);
      #1;
      we = 0; rd_en = '0; clr_req = 0;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_reset_outputs();
      model_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Preset entry and an ordinary zero entry.
      cycle(0, 0, 0, 2'b11, 5'd16, 5'd5, 0);
      // Write then read on both ports; zero register ignores writes.
      cycle(1, 5'd7, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
      cycle(0, 0, 0, 2'b11, 5'd7, 5'd7, 0);
      cycle(1, 5'd0, 32'h1234, 2'b00, 0, 0, 0);
      cycle(0, 0, 0, 2'b11, 5'd0, 5'd0, 0);
      // Read-enable hold.
      cycle(1, 5'd3, 32'h33, 2'b00, 0, 0, 0);
      cycle(1, 5'd4, 32'h44, 2'b00, 0, 0, 0);
      cycle(0, 0, 0, 2'b11, 5'd3, 5'd3, 0);
      for (int i = 0; i < 5; i++)
         cycle(0, 0, 0, 2'b10, 5'd4, 5'd4, 0);
      // Same-cycle write/read of address 9.
      cycle(1, 5'd9, 32'hA5A5, 2'b10, 5'd0, 5'd9, 0);
      cycle(1, 5'd9, 32'h5A5A, 2'b11, 5'd9, 5'd9, 0);
      cycle(0, 0, 0, 2'b11, 5'd9, 5'd9, 0);

      // Fill, clear with a dropped write to address 2, then read back everything.
      for (int i = 0; i < DEPTH; i++)
         cycle(1, 5'(i), 32'hFFFF_FFFF, 2'b00, 0, 0, 0);
      cycle(0, 0, 0, 2'b00, 0, 0, 1);
      for (int i = 0; i < DEPTH + 1; i++)
         cycle(i == 3 || i == DEPTH, 5'd2, 32'h1111, 2'b11, 5'(i), 5'd2, 1);
      for (int i = 0; i < DEPTH; i++)
         cycle(0, 0, 0, 2'b11, 5'(i), 5'(DEPTH - 1 - i), 0);

      // Reset partway through a clear, then a fresh clear afterwards.
      cycle(1, 5'd12, 32'hCAFE, 2'b00, 0, 0, 1);
      for (int i = 0; i < 9; i++)
         cycle(0, 0, 0, 2'b11, 5'(i), 5'd16, 0);
      mid_reset();
      for (int i = 0; i < 3; i++)
         cycle(0, 0, 0, 2'b11, 5'd12, 5'd16, 0);
      cycle(1, 5'd20, 32'h2020, 2'b00, 0, 0, 0);
      cycle(0, 0, 0, 2'b00, 0, 0, 1);
      for (int i = 0; i < DEPTH + 3; i++)
         cycle(0, 0, 0, 2'b11, 5'd20, 5'(i), 0);

      // Randomised traffic with a narrow address range to force collisions.
      for (int i = 0; i < 1500; i++) begin
         logic [4:0] wa, a0, a1;
         wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         a0 = 5'($urandom_range(0, 7));
         a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         cycle(1'($urandom), wa, $urandom, 2'($urandom), a0, a1, $urandom_range(0, 99) == 0);
      end

      cycle(0, 0, 0, 2'b00, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised register file for the multicycle datapath. It has NRD registered read ports and one write port, with an optional write-to-read bypass and a hardwired zero register. It adds a preset register that is loaded on reset, and a sequential clear engine that scrubs the array one entry per cycle under a request/busy/done handshake. It replaces the fixed 32x32 two-read-port register file in the decode stage.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries
- NRD, 2: number of read ports (≥1)
- BYPASS, 1: 1 = write-first forwarding to same-cycle reads; 0 = read-old-data
- ZERO_REG, 1: 1 = entry 0 reads 0 and ignores writes
- PRESET_IDX, 16: entry loaded with PRESET_VAL on reset and on clear
- PRESET_VAL, 32'h17: preset value (data-memory word 23 pointer for $s0)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  NRD  per-port read enable; bit k controls port k
- rd_addr  in  NRD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  registered read data; port k = bits [k*DATA_W +: DATA_W]
- clr_req  in  1  single-cycle clear request
- clr_busy  out  1  high while the clear engine is walking the array
- clr_done  out  1  one-cycle pulse when the clear completes

## Operation
- **Array reset:** while rst_n=0, all entries are 0, except entry PRESET_IDX = PRESET_VAL. If ZERO_REG=1 and PRESET_IDX=0, entry 0 stays 0.
- **Output reset:** rd_data=0, clr_busy=0, clr_done=0, FSM in IDLE, clear index 0.
- **Write:** when we=1 and the FSM is IDLE, mem[wr_addr] <= wr_data. Ignored if ZERO_REG=1 and wr_addr=0.
- **Read:** when rd_en[k]=1, port k captures the entry at rd_addr_k. When rd_en[k]=0, port k holds its previous value.
- **Zero register:** if ZERO_REG=1, a read of address 0 returns 0.
- **Bypass (BYPASS=1):** if an accepted write in the same cycle targets rd_addr_k, port k captures wr_data.
  - Forwarding never applies to address 0 when ZERO_REG=1.
  - With BYPASS=0, port k captures the pre-write contents.
- **Multiple ports:** any number of ports may read the same address in the same cycle; all receive identical data.
- **Clear FSM:**
  - IDLE → CLEAR when clr_req=1. The index is set to 0 and clr_busy rises the next cycle.
  - CLEAR: each cycle, entry[index] <= (index==PRESET_IDX ? PRESET_VAL : 0) and the index increments.
  - CLEAR → DONE after entry DEPTH-1 is written. The index wraps to 0.
  - DONE: clr_done=1 for one cycle, clr_busy=0, then → IDLE.
- **During CLEAR and DONE:**
  - we is ignored: no write, no bypass.
  - clr_req is ignored.
  - Reads proceed normally and return current contents, i.e. already-cleared entries read their cleared value.
- **Reset mid-clear:** the array, outputs and FSM return to the reset values immediately. The clear is abandoned and no clr_done is generated.

## Timing
- **Read latency:** 1 cycle. Address presented at edge N appears on rd_data after edge N+1 and is held until the next enabled read.
- **Write visibility:** the write at edge N is visible to a non-bypassed read issued at edge N+1.
- **Clear sequence:** clr_req sampled at edge N.
  - clr_busy is high for edges N+1 … N+DEPTH.
  - Entry i is cleared at edge N+1+i.
  - clr_done is high for the single cycle after edge N+DEPTH.
  - IDLE resumes, and writes are accepted again, from edge N+DEPTH+1.
- **Total clear:** DEPTH+1 cycles from request to IDLE.
- **Reset:** rst_n assertion takes effect without a clock edge. Deassertion is synchronised externally; the block requires rst_n to rise away from a clk edge.

## Test plan
- **Reset preset:** assert rst_n=0 mid-cycle, then release. All rd_data=0. Read addresses 16 and 5 on ports 0 and 1 → 32'h17 and 0 after one cycle.
- **Write and read:**
  - Write 32'hDEAD_BEEF to address 7, then read address 7 on both ports next cycle → both 32'hDEAD_BEEF.
  - Write 32'h1234 to address 0 → reads 0.
- **Bypass:**
  - BYPASS=1: write 32'hA5A5 to address 9 while port 1 reads address 9 in the same cycle → 32'hA5A5.
  - BYPASS=0, same stimulus → the old value of address 9.
- **Read enable:** read address 3 (value 32'h33), then drop rd_en[0] and change rd_addr_0 to address 4 (value 32'h44). rd_data port 0 stays 32'h33 for 5 cycles.
- **Clear:**
  - Fill all entries with 32'hFFFF_FFFF, then pulse clr_req. clr_busy is high exactly 32 cycles, then clr_done pulses for 1 cycle.
  - A write to address 2 issued during busy is dropped.
  - Afterwards, every entry reads 0, except address 16 = 32'h17.
- **Reset mid-clear:** assert rst_n=0 at busy cycle 10 → clr_busy drops immediately, no clr_done, array at reset values, FSM accepts a new clr_req after release.
